idecode_nw_ctrl: RTL and testbench

//  N-wide decode-stage issue controller, successor of the 2-wide decode control.

---
 rtl/idecode_nw_ctrl_pkg.sv | 33 +++
 rtl/idecode_nw_ctrl_dec_issue_select.sv | 53 +++++
 rtl/idecode_nw_ctrl.sv | 126 ++++++++++++
 tb/tb_idecode_nw_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idecode_nw_ctrl_pkg.sv
// Shared types and helpers for the N-wide decode issue controller.
// Default widths mirror the reference configuration (2 lanes, 4 branch tags).
package idecode_nw_ctrl_pkg;

  localparam int DEF_DEC_WIDTH     = 2;
  localparam int DEF_MAX_BRANCH_IF = 4;
  localparam int DEF_PC_BITS       = 32;
  localparam int DEF_TAG_BITS      = $clog2(DEF_MAX_BRANCH_IF);

  typedef logic [DEF_TAG_BITS-1:0] br_tag_t;

  typedef struct packed {
    logic                   valid;
    br_tag_t                tag;
    logic                   mispred;
    logic [DEF_PC_BITS-1:0] pc;
  } br_resolve_t;

  typedef struct packed {
    logic valid;
    logic is_branch;
  } dec_lane_ctrl_t;

  function automatic int count_ones(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/idecode_nw_ctrl_dec_issue_select.sv
// Combinational issue selection: longest issuable lane prefix and per-lane
// count of older branches used to derive branch tags.
module dec_issue_select
  import idecode_nw_ctrl_pkg::*;
#(
  parameter int DEC_WIDTH = 2,
  parameter int CNT_BITS  = 2,
  parameter int FREE_BITS = 3
) (
  input  logic                               en_i,
  input  logic [DEC_WIDTH-1:0]               in_valid_i,
  input  logic [DEC_WIDTH-1:0]               in_is_branch_i,
  input  logic [CNT_BITS-1:0]                iq_free_i,
  input  logic [FREE_BITS-1:0]               free_i,
  output logic [CNT_BITS-1:0]                k_o,
  output logic [CNT_BITS-1:0]                nbr_o,
  output logic [DEC_WIDTH-1:0]               mask_o,
  output logic [DEC_WIDTH-1:0][CNT_BITS-1:0] off_o
);

  dec_lane_ctrl_t lane;
  int             nk;
  int             nb;
  int             pre;
  logic           stop;

  always_comb begin
    nk     = 0;
    nb     = 0;
    pre    = 0;
    stop   = 1'b0;
    lane   = '0;
    mask_o = '0;
    off_o  = '0;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      lane     = '{valid: in_valid_i[i], is_branch: in_is_branch_i[i]};
      off_o[i] = CNT_BITS'(pre);
      if (lane.is_branch) pre++;
      // First lane that fails any condition ends the prefix; later lanes never skip ahead.
      if (!stop && en_i && lane.valid && (i < int'(iq_free_i)) &&
          (!lane.is_branch || (nb < int'(free_i)))) begin
        mask_o[i] = 1'b1;
        nk++;
        if (lane.is_branch) nb++;
      end else begin
        stop = 1'b1;
      end
    end
    k_o   = CNT_BITS'(nk);
    nbr_o = CNT_BITS'(nb);
  end

endmodule

// File: rtl/idecode_nw_ctrl.sv
// N-wide decode issue controller: branch-tag ring with out-of-order resolve,
// in-order retire, and mispredict flush with tail rollback.
module idecode_nw_ctrl
  import idecode_nw_ctrl_pkg::*;
#(
  parameter  int DEC_WIDTH     = DEF_DEC_WIDTH,
  parameter  int MAX_BRANCH_IF = DEF_MAX_BRANCH_IF,
  parameter  int PC_BITS       = DEF_PC_BITS,
  localparam int TAG_BITS      = $clog2(MAX_BRANCH_IF),
  localparam int CNT_BITS      = $clog2(DEC_WIDTH + 1),
  localparam int PTR_BITS      = TAG_BITS + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DEC_WIDTH-1:0]          in_valid,
  input  logic [DEC_WIDTH-1:0]          in_is_branch,
  input  logic [CNT_BITS-1:0]           iq_free,
  output logic [CNT_BITS-1:0]           in_accept_cnt,
  output logic [DEC_WIDTH-1:0]          out_valid,
  output logic [DEC_WIDTH*TAG_BITS-1:0] out_br_tag,
  input  logic                          resolve_valid,
  input  logic [TAG_BITS-1:0]           resolve_tag,
  input  logic                          resolve_mispred,
  input  logic [PC_BITS-1:0]            resolve_pc,
  output logic                          flush_o,
  output logic [PC_BITS-1:0]            flush_pc_o,
  output logic [TAG_BITS-1:0]           flush_tag_o,
  output logic [PTR_BITS-1:0]           branch_if_o
);

  logic [PTR_BITS-1:0]      head_q, head_d, tail_q, tail_d, occ, free;
  logic [MAX_BRANCH_IF-1:0] resolved_q, resolved_d;
  logic                     flush_q, flush_d;
  logic [PC_BITS-1:0]       flush_pc_q, flush_pc_d;
  logic [TAG_BITS-1:0]      flush_tag_q, flush_tag_d;
  logic [TAG_BITS-1:0]      head_tag, tail_tag, res_dist;
  logic                     res_live, mispred, issue_en;
  logic [CNT_BITS-1:0]      k, nbr;
  logic [DEC_WIDTH-1:0]     mask;

  logic [DEC_WIDTH-1:0][CNT_BITS-1:0] off;
  logic [DEC_WIDTH-1:0][TAG_BITS-1:0] lane_tag;

  assign occ      = tail_q - head_q;
  assign free     = PTR_BITS'(MAX_BRANCH_IF) - occ;
  assign head_tag = head_q[TAG_BITS-1:0];
  assign tail_tag = tail_q[TAG_BITS-1:0];
  // A tag is live when its distance from head is below the occupancy.
  assign res_dist = resolve_tag - head_tag;
  assign res_live = resolve_valid && ({1'b0, res_dist} < occ);
  assign mispred  = res_live && resolve_mispred;
  assign issue_en = !rst && !flush_q && !mispred;

  dec_issue_select #(
    .DEC_WIDTH (DEC_WIDTH),
    .CNT_BITS  (CNT_BITS),
    .FREE_BITS (PTR_BITS)
  ) u_sel (
    .en_i           (issue_en),
    .in_valid_i     (in_valid),
    .in_is_branch_i (in_is_branch),
    .iq_free_i      (iq_free),
    .free_i         (free),
    .k_o            (k),
    .nbr_o          (nbr),
    .mask_o         (mask),
    .off_o          (off)
  );

  always_comb begin
    lane_tag = '0;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      lane_tag[i] = tail_tag + TAG_BITS'(off[i]) - TAG_BITS'(!in_is_branch[i]);
    end
  end

  assign out_valid     = mask;
  assign out_br_tag    = lane_tag;
  assign in_accept_cnt = flush_q ? CNT_BITS'(count_ones(32'(in_valid))) : k;
  assign flush_o       = flush_q;
  assign flush_pc_o    = flush_pc_q;
  assign flush_tag_o   = flush_tag_q;
  assign branch_if_o   = occ;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q + PTR_BITS'(nbr);
    resolved_d  = resolved_q;
    flush_d     = mispred;
    flush_pc_d  = flush_pc_q;
    flush_tag_d = flush_tag_q;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      if (mask[i] && in_is_branch[i]) resolved_d[lane_tag[i]] = 1'b0;
    end
    if (res_live) resolved_d[resolve_tag] = 1'b1;
    // Rollback keeps the mispredicted tag; rebuilding from head preserves the wrap bit.
    if (mispred) begin
      tail_d      = head_q + PTR_BITS'(res_dist) + PTR_BITS'(1);
      flush_pc_d  = resolve_pc;
      flush_tag_d = resolve_tag;
    end
    if ((occ != '0) && resolved_q[head_tag]) head_d = head_q + PTR_BITS'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      resolved_q  <= '0;
      flush_q     <= 1'b0;
      flush_pc_q  <= '0;
      flush_tag_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      resolved_q  <= resolved_d;
      flush_q     <= flush_d;
      flush_pc_q  <= flush_pc_d;
      flush_tag_q <= flush_tag_d;
    end
  end

  resolve_in_range: assert property (@(posedge clk) disable iff (rst)
    resolve_valid |-> res_live);

endmodule

// File: tb/tb_idecode_nw_ctrl.sv
// Bench for idecode_nw_ctrl: directed scenarios plus random traffic checked
// against a queue-based model of the in-flight branch list.
module tb_idecode_nw_ctrl;

  localparam int DW = 2;
  localparam int MB = 4;
  localparam int TB = 2;
  localparam int CB = 2;
  localparam int PB = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_valid = '0, in_is_branch = '0;
  logic [CB-1:0] iq_free = '0;
  logic [CB-1:0] in_accept_cnt;
  logic [DW-1:0] out_valid;
  logic [DW*TB-1:0] out_br_tag;
  logic          resolve_valid = 1'b0, resolve_mispred = 1'b0;
  logic [TB-1:0] resolve_tag = '0;
  logic [PB-1:0] resolve_pc = '0;
  logic          flush_o;
  logic [PB-1:0] flush_pc_o;
  logic [TB-1:0] flush_tag_o;
  logic [TB:0]   branch_if_o;

  always #5 clk = ~clk;

  idecode_nw_ctrl #(.DEC_WIDTH(DW), .MAX_BRANCH_IF(MB), .PC_BITS(PB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_is_branch(in_is_branch),
    .iq_free(iq_free), .in_accept_cnt(in_accept_cnt), .out_valid(out_valid),
    .out_br_tag(out_br_tag), .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispred(resolve_mispred), .resolve_pc(resolve_pc), .flush_o(flush_o),
    .flush_pc_o(flush_pc_o), .flush_tag_o(flush_tag_o), .branch_if_o(branch_if_o)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Model: in-flight tags oldest-first with their resolved flags.
  int          ltag[$];
  bit          lres[$];
  int          next_tag;
  bit          m_fl;
  logic [PB-1:0] m_fl_pc;
  int          m_fl_tag;
  int          e_k;
  logic [DW-1:0] e_mask;
  int          e_tag[DW];
  bit          e_mp;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int live_idx(input int t);
    for (int i = 0; i < ltag.size(); i++) if (ltag[i] == t) return i;
    return -1;
  endfunction

  task automatic model_reset();
    ltag.delete();
    lres.delete();
    next_tag = 0;
    m_fl = 0;
    m_fl_pc = '0;
    m_fl_tag = 0;
  endtask

  task automatic model_eval();
    int pre;
    int idx;
    int fr;
    idx  = live_idx(int'(resolve_tag));
    e_mp = resolve_valid && (idx >= 0) && resolve_mispred;
    e_k = 0;
    pre = 0;
    for (int i = 0; i < DW; i++) begin
      e_tag[i] = (next_tag + pre + (in_is_branch[i] ? 0 : MB - 1)) % MB;
      if (in_is_branch[i]) pre++;
    end
    if (m_fl) begin
      e_k = $countones(in_valid);
      e_mask = '0;
    end else begin
      if (!e_mp) begin
        fr = MB - ltag.size();
        for (int j = 0; j <= DW; j++) begin
          int nb;
          bit ok;
          nb = 0;
          ok = (j <= int'(iq_free));
          for (int i = 0; i < j; i++) begin
            if (!in_valid[i]) ok = 0;
            if (in_is_branch[i]) nb++;
          end
          if (nb > fr) ok = 0;
          if (ok) e_k = j;
        end
      end
      e_mask = DW'((1 << e_k) - 1);
    end
  endtask

  task automatic model_update();
    bit ret;
    int idx;
    ret = (ltag.size() > 0) && lres[0];
    idx = live_idx(int'(resolve_tag));
    if (resolve_valid && idx >= 0) begin
      lres[idx] = 1'b1;
      if (resolve_mispred) begin
        while (ltag.size() > idx + 1) begin
          void'(ltag.pop_back());
          void'(lres.pop_back());
        end
        next_tag = (int'(resolve_tag) + 1) % MB;
      end
    end
    for (int i = 0; i < DW; i++) begin
      if (e_mask[i] && in_is_branch[i]) begin
        ltag.push_back(next_tag);
        lres.push_back(1'b0);
        next_tag = (next_tag + 1) % MB;
      end
    end
    if (ret) begin
      void'(ltag.pop_front());
      void'(lres.pop_front());
    end
    m_fl = e_mp;
    if (e_mp) begin
      m_fl_pc = resolve_pc;
      m_fl_tag = int'(resolve_tag);
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    chk("accept", 64'(in_accept_cnt), 64'(e_k));
    chk("out_valid", 64'(out_valid), 64'(e_mask));
    for (int i = 0; i < DW; i++) begin
      if (e_mask[i]) chk("lane_tag", 64'(out_br_tag[i*TB +: TB]), 64'(e_tag[i]));
    end
    chk("flush", 64'(flush_o), 64'(m_fl));
    chk("flush_pc", 64'(flush_pc_o), 64'(m_fl_pc));
    chk("flush_tag", 64'(flush_tag_o), 64'(m_fl_tag));
    chk("branch_if", 64'(branch_if_o), 64'(ltag.size()));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic [DW-1:0] v, input logic [DW-1:0] b, input int f,
                        input bit rv, input int rt, input bit rm, input logic [PB-1:0] rp);
    in_valid = v;
    in_is_branch = b;
    iq_free = CB'(f);
    resolve_valid = rv;
    resolve_tag = TB'(rt);
    resolve_mispred = rm;
    resolve_pc = rp;
  endtask

  initial begin
    model_reset();
    set_in(2'b11, 2'b00, 2, 0, 0, 0, '0);
    repeat (2) @(negedge clk);
    chk("rst_flush", 64'(flush_o), 64'(0));
    chk("rst_branch_if", 64'(branch_if_o), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_accept", 64'(in_accept_cnt), 64'(0));
    chk("rst_flush_pc", 64'(flush_pc_o), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Plain issue, then fill three tags and hit the free-tag limit.
    set_in(2'b11, 2'b00, 2, 0, 0, 0, '0); step();
    set_in(2'b11, 2'b11, 2, 0, 0, 0, '0); step();
    set_in(2'b01, 2'b01, 2, 0, 0, 0, '0); step();
    set_in(2'b11, 2'b11, 2, 0, 0, 0, '0);
    #1;
    chk("lim_out_valid", 64'(out_valid), 64'(2'b01));
    chk("lim_tag0", 64'(out_br_tag[TB-1:0]), 64'(3));
    chk("lim_accept", 64'(in_accept_cnt), 64'(1));
    step();

    // Mispredict tag 1 with all four tags live.
    set_in(2'b00, 2'b00, 2, 1, 1, 1, 32'h80); step();
    set_in(2'b11, 2'b00, 2, 0, 0, 0, '0);
    #1;
    chk("mp_flush", 64'(flush_o), 64'(1));
    chk("mp_pc", 64'(flush_pc_o), 64'(32'h80));
    chk("mp_tag", 64'(flush_tag_o), 64'(1));
    chk("mp_branch_if", 64'(branch_if_o), 64'(2));
    chk("mp_out_valid", 64'(out_valid), 64'(0));
    chk("mp_drain", 64'(in_accept_cnt), 64'(2));
    step();
    set_in(2'b00, 2'b00, 2, 1, 0, 0, '0); step();
    set_in(2'b00, 2'b00, 2, 0, 0, 0, '0); step(); step(); step();
    chk("empty_branch_if", 64'(branch_if_o), 64'(0));

    // Walk the ring to head=tail=3, then allocate across the wrap.
    set_in(2'b01, 2'b01, 2, 0, 0, 0, '0); step();
    set_in(2'b00, 2'b00, 2, 1, 2, 0, '0); step();
    set_in(2'b00, 2'b00, 2, 0, 0, 0, '0); step(); step();
    set_in(2'b11, 2'b11, 2, 0, 0, 0, '0);
    #1;
    chk("wrap_tag0", 64'(out_br_tag[TB-1:0]), 64'(3));
    chk("wrap_tag1", 64'(out_br_tag[2*TB-1:TB]), 64'(0));
    step();
    chk("wrap_branch_if", 64'(branch_if_o), 64'(2));

    // Full ring: only non-branch lanes ahead of the first branch issue.
    set_in(2'b11, 2'b11, 2, 0, 0, 0, '0); step();
    set_in(2'b11, 2'b10, 2, 0, 0, 0, '0);
    #1;
    chk("full_accept_nb", 64'(in_accept_cnt), 64'(1));
    step();
    set_in(2'b11, 2'b01, 2, 0, 0, 0, '0);
    #1;
    chk("full_accept_br", 64'(in_accept_cnt), 64'(0));
    step();

    // Reset arriving during a flush pulse.
    set_in(2'b00, 2'b00, 2, 1, 3, 1, 32'h1234); step();
    set_in(2'b00, 2'b00, 2, 0, 0, 0, '0);
    #2;
    chk("pre_rst_flush", 64'(flush_o), 64'(1));
    rst = 1'b1;
    #1;
    chk("midrst_flush", 64'(flush_o), 64'(0));
    chk("midrst_branch_if", 64'(branch_if_o), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Out-of-order resolve followed by in-order retire.
    set_in(2'b11, 2'b11, 2, 0, 0, 0, '0); step();
    set_in(2'b01, 2'b01, 2, 0, 0, 0, '0); step();
    set_in(2'b00, 2'b00, 2, 1, 1, 0, '0); step();
    set_in(2'b00, 2'b00, 2, 1, 0, 0, '0); step();
    set_in(2'b00, 2'b00, 2, 0, 0, 0, '0);
    chk("ooo_if_a", 64'(branch_if_o), 64'(3));
    step();
    chk("ooo_if_b", 64'(branch_if_o), 64'(2));
    step();
    chk("ooo_if_c", 64'(branch_if_o), 64'(1));
    step();

    repeat (1500) begin
      int nv;
      nv = $urandom_range(0, DW);
      in_valid = DW'((1 << nv) - 1);
      in_is_branch = DW'($urandom);
      iq_free = CB'($urandom_range(0, DW));
      resolve_pc = $urandom;
      if (ltag.size() > 0 && ($urandom % 3) == 0) begin
        resolve_valid = 1'b1;
        resolve_tag = TB'(ltag[$urandom_range(0, ltag.size() - 1)]);
        resolve_mispred = (($urandom % 6) == 0);
      end else begin
        resolve_valid = 1'b0;
        resolve_tag = TB'($urandom);
        resolve_mispred = 1'($urandom);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
